// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port among N_REQ valid/ready producers.
// Accepted beat reaches fifo_wr_en/fifo_data_in one cycle later; req_ready is withheld while the FIFO cannot take another write.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_almostfull,
  input  logic                    fifo_wr_ack,
  input  logic                    fifo_overflow,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_data_in,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    drop_err
);

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W-1:0]   fifo_data_in_q, fifo_data_in_d;
  logic                ack_pend_q, ack_pend_d;
  logic                drop_err_q, drop_err_d;
  logic                busy_q, busy_d;

  logic                can_issue;
  logic                burst_full;
  logic                sel_vld;
  logic [ID_W-1:0]     sel_idx;
  logic [ID_W-1:0]     cand;
  logic                acc_vld;
  logic [ID_W-1:0]     acc_idx;

  // First requester strictly after the last owner, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    // The write already registered may consume the last free slot.
    can_issue   = !fifo_full && !(fifo_wr_en_q && fifo_almostfull);
    burst_full  = (burst_cnt_q == BW'(MAX_BURST));
    acc_vld     = 1'b0;
    acc_idx     = grant_id_q;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (sel_vld && can_issue) begin
          acc_vld     = 1'b1;
          acc_idx     = sel_idx;
          grant_id_d  = sel_idx;
          burst_cnt_d = BW'(1);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req[grant_id_q] || burst_full) begin
          rr_ptr_d    = grant_id_q;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end else if (can_issue) begin
          acc_vld     = 1'b1;
          burst_cnt_d = burst_cnt_q + BW'(1);
        end else begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!req[grant_id_q]) begin
          rr_ptr_d    = grant_id_q;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end else if (can_issue) begin
          acc_vld     = 1'b1;
          burst_cnt_d = burst_cnt_q + BW'(1);
          state_d     = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      acc_vld = 1'b0;
    end

    req_ready = '0;
    if (acc_vld) begin
      req_ready[acc_idx] = 1'b1;
    end

    fifo_wr_en_d   = acc_vld;
    fifo_data_in_d = acc_vld ? req_data[acc_idx*DATA_W +: DATA_W] : fifo_data_in_q;
    ack_pend_d     = fifo_wr_en_q;
    drop_err_d     = drop_err_q | (ack_pend_q && (!fifo_wr_ack || fifo_overflow));
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= ID_W'(N_REQ - 1);
      grant_id_q     <= '0;
      burst_cnt_q    <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_data_in_q <= '0;
      ack_pend_q     <= 1'b0;
      drop_err_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      burst_cnt_q    <= burst_cnt_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_data_in_q <= fifo_data_in_d;
      ack_pend_q     <= ack_pend_d;
      drop_err_q     <= drop_err_d;
      busy_q         <= busy_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_data_in = fifo_data_in_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter against a depth-8 behavioural FIFO and simple requester models.
module tb_fifo_write_arbiter;
  localparam int N_REQ     = 4;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 8;
  localparam int LOG_SZ    = 512;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy, drop_err;

  int errors = 0;
  int checks = 0;

  logic [3:0]  en;
  int          left [4];
  logic [15:0] nxt [4];
  logic [3:0]  hs;

  int          cnt = 0;
  int          cyc = 0;
  int          log_n = 0;
  logic [15:0] log_dat [LOG_SZ];
  int          log_cyc [LOG_SZ];
  logic        ack_q = 1'b0, ov_q = 1'b0, ov_seen = 1'b0;
  logic        ack_kill = 1'b0, rd = 1'b0;

  fifo_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy), .drop_err(drop_err)
  );

  // Behavioural FIFO write side plus a log of every issued write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_wr_en && log_n < LOG_SZ) begin
      log_dat[log_n] <= fifo_data_in;
      log_cyc[log_n] <= cyc;
      log_n          <= log_n + 1;
    end
    if (rst) begin
      cnt   <= 0;
      ack_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      cnt   <= cnt + ((fifo_wr_en && cnt < DEPTH) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
      ack_q <= fifo_wr_en && (cnt < DEPTH);
      ov_q  <= fifo_wr_en && (cnt == DEPTH);
      if (ov_q) ov_seen <= 1'b1;
    end
  end

  assign fifo_full       = (cnt == DEPTH);
  assign fifo_almostfull = (cnt == DEPTH - 1);
  assign fifo_wr_ack     = ack_q && !ack_kill;
  assign fifo_overflow   = ov_q;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = en[i] && (left[i] > 0);
      req_data[i*16 +: 16] = nxt[i];
    end
  endtask

  task automatic tick();
    hs = req & req_ready;
    checks++;
    if (!$onehot0(req_ready)) begin
      errors++;
      $display("FAIL ready_onehot: req_ready=%b required at most one bit", req_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        left[i]--;
        nxt[i]++;
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd = 1'b0; ack_kill = 1'b0; en = 4'h0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      nxt[i]  = 16'(i << 8);
    end
    drive();
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bit found;
    rst = 1'b1; rd = 1'b1; ack_kill = 1'b0; en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      left[i] = 1;
      nxt[i]  = 16'(i << 8);
    end
    drive();
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
      tick();
      checks++;
      if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++;
      if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
      checks++;
      if (drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop_err: got %b want 0", drop_err); end
    end
    rst = 1'b0;
    #1;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      tick();
      found = fifo_wr_en;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_first_write: no write within 6 cycles of release");
    end else begin
      checks++;
      if (fifo_data_in !== 16'h0000) begin errors++; $display("FAIL rst_first_owner: got %h want 0000", fifo_data_in); end
      checks++;
      if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_first_grant: got %0d want 0", grant_id); end
    end
  endtask

  task automatic test_round_robin();
    int start;
    logic [15:0] exp_d;
    do_reset();
    rd = 1'b1; en = 4'hF;
    for (int i = 0; i < 4; i++) left[i] = 8;
    drive();
    #1;
    start = log_n;
    for (int c = 0; c < 30; c++) tick();
    checks++;
    if (log_n - start < 20) begin
      errors++;
      $display("FAIL rr_count: got %0d writes want at least 20", log_n - start);
    end else begin
      for (int k = 0; k < 20; k++) begin
        exp_d = 16'((((k / 4) % 4) << 8) | ((k / 16) * 4 + (k % 4)));
        checks++;
        if (log_dat[start+k] !== exp_d) begin
          errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, log_dat[start+k], exp_d);
        end
        if (k > 0) begin
          checks++;
          if (log_cyc[start+k] - log_cyc[start+k-1] != ((k % 4 == 0) ? 2 : 1)) begin
            errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k,
                               log_cyc[start+k] - log_cyc[start+k-1], (k % 4 == 0) ? 2 : 1);
          end
        end
      end
    end
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL rr_drop_err: got %b want 0", drop_err); end
  endtask

  task automatic test_throttle(output int start);
    do_reset();
    rd = 1'b0; en = 4'b0010; left[1] = 12; nxt[1] = 16'h0100;
    drive();
    #1;
    start = log_n;
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (log_n - start != 8) begin errors++; $display("FAIL thr_count: got %0d want 8", log_n - start); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (log_dat[start+k] !== 16'(16'h0100 + k)) begin
        errors++; $display("FAIL thr_data[%0d]: got %h want %h", k, log_dat[start+k], 16'(16'h0100 + k));
      end
    end
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL thr_ready: got %b want 0000", req_ready); end
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL thr_full: got %b want 1", fifo_full); end
    checks++;
    if (ov_seen !== 1'b0) begin errors++; $display("FAIL thr_overflow: got %b want 0", ov_seen); end
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL thr_drop_err: got %b want 0", drop_err); end
  endtask

  task automatic test_resume(input int start);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (log_n - start != 9) begin errors++; $display("FAIL res_count: got %0d want 9", log_n - start); end
    checks++;
    if (log_dat[start+8] !== 16'h0108) begin errors++; $display("FAIL res_data: got %h want 0108", log_dat[start+8]); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL res_busy: got %b want 1", busy); end
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL res_ready: got %b want 0000", req_ready); end
    checks++;
    if (left[1] != 3) begin errors++; $display("FAIL res_left: got %0d want 3", left[1]); end
    checks++;
    if (ov_seen !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL res_err: overflow=%b drop_err=%b want 0 0", ov_seen, drop_err);
    end
  endtask

  task automatic test_handover();
    int start;
    logic [15:0] exp_d [8];
    int          exp_gap [8];
    exp_d   = '{16'h0000, 16'h0001, 16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0002, 16'h0003};
    exp_gap = '{0, 1, 2, 1, 1, 1, 2, 1};
    do_reset();
    rd = 1'b1; en = 4'b0101; left[0] = 2; left[2] = 8;
    drive();
    #1;
    start = log_n;
    for (int c = 0; c < 4; c++) tick();
    left[0] = 2;
    drive();
    #1;
    for (int c = 0; c < 12; c++) tick();
    checks++;
    if (log_n - start < 8) begin
      errors++; $display("FAIL ho_count: got %0d writes want at least 8", log_n - start);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (log_dat[start+k] !== exp_d[k]) begin
          errors++; $display("FAIL ho_data[%0d]: got %h want %h", k, log_dat[start+k], exp_d[k]);
        end
        if (k > 0) begin
          checks++;
          if (log_cyc[start+k] - log_cyc[start+k-1] != exp_gap[k]) begin
            errors++; $display("FAIL ho_gap[%0d]: got %0d want %0d", k,
                               log_cyc[start+k] - log_cyc[start+k-1], exp_gap[k]);
          end
        end
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    rd = 1'b1; en = 4'b1000; left[3] = 1;
    drive();
    #1;
    ack_kill = 1'b1;
    tick();
    checks++;
    if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL flt_wr_en: got %b want 1", fifo_wr_en); end
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL flt_early1: got %b want 0", drop_err); end
    tick();
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL flt_early2: got %b want 0", drop_err); end
    tick();
    ack_kill = 1'b0;
    checks++;
    if (drop_err !== 1'b1) begin errors++; $display("FAIL flt_set: got %b want 1", drop_err); end
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (drop_err !== 1'b1) begin errors++; $display("FAIL flt_sticky: got %b want 1", drop_err); end
    do_reset();
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL flt_clear: got %b want 0", drop_err); end
  endtask

  initial begin
    int thr_start;
    test_reset();
    test_round_robin();
    test_throttle(thr_start);
    test_resume(thr_start);
    test_handover();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
